// File: rtl/sample_rom_fetch_pkg.sv
// Shared types for the MCU sample-playback fetch path.
// Imported by sample_rom_fetch.
package m72_sample_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    localparam int SAMPLE_ADDR_W = 16;

endpackage

// File: rtl/sample_rom_fetch.sv
// MCU sample-ROM responder: address register, req/ack fetch FSM, data buffer.
// Optional SAMPLE_PREFETCH_EN adds a background fetch of addr+1.
module sample_rom_fetch
    import m72_sample_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 25,
    parameter logic [ADDR_W-1:0]   SAMPLE_BASE = '0
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic [1:0]        sample_addr_wr,
    input  logic [7:0]        sample_addr,
    input  logic              sample_inc,
    output logic [7:0]        sample_rom_data,
    output logic              sample_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data
);

    fetch_state_t             state_q, state_d;
    logic [SAMPLE_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]               data_q, data_d;
    logic                     ready_q, ready_d;
    logic                     req_q, req_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic                     boot_q;
    logic                     wr;
    logic                     trig;

`ifdef SAMPLE_PREFETCH_EN
    logic [7:0]               pf_data_q, pf_data_d;
    logic                     pf_valid_q, pf_valid_d;
    logic                     pf_fetch_q, pf_fetch_d;
`endif

    function automatic logic [ADDR_W-1:0] mem_addr(
        input logic [SAMPLE_ADDR_W-1:0] a
    );
        return SAMPLE_BASE + {{(ADDR_W-SAMPLE_ADDR_W){1'b0}}, a};
    endfunction

    // boot_q turns the first cycle after reset into an implicit trigger
    assign wr   = |sample_addr_wr;
    assign trig = wr | sample_inc | boot_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ready_d    = ready_q;
        req_d      = req_q;
        rom_addr_d = rom_addr_q;
`ifdef SAMPLE_PREFETCH_EN
        pf_data_d  = pf_data_q;
        pf_valid_d = pf_valid_q;
        pf_fetch_d = pf_fetch_q;
`endif

        if (sample_addr_wr[0]) addr_d[7:0]  = sample_addr;
        if (sample_addr_wr[1]) addr_d[15:8] = sample_addr;
        if (!wr && sample_inc) addr_d = addr_q + 16'd1;

        unique case (state_q)
            IDLE: begin
`ifdef SAMPLE_PREFETCH_EN
                if (!wr && sample_inc && pf_valid_q) begin
                    data_d     = pf_data_q;
                    pf_valid_d = 1'b0;
                end else if (trig) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    ready_d    = 1'b0;
                    pf_valid_d = 1'b0;
                    rom_addr_d = mem_addr(addr_d);
                end else if (ready_q && !pf_valid_q) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    pf_fetch_d = 1'b1;
                    rom_addr_d = mem_addr(addr_q + 16'd1);
                end
`else
                if (trig) begin
                    state_d    = REQ;
                    req_d      = 1'b1;
                    ready_d    = 1'b0;
                    rom_addr_d = mem_addr(addr_d);
                end
`endif
            end
            REQ: begin
`ifdef SAMPLE_PREFETCH_EN
                if (pf_fetch_q) begin
                    pf_fetch_d = 1'b0;
                    if (wr) begin
                        ready_d = 1'b0;
                        if (rom_ack) rom_addr_d = mem_addr(addr_d);
                        else         state_d    = DISCARD;
                    end else if (sample_inc) begin
                        // in-flight prefetch already targets the new address
                        if (rom_ack) begin
                            data_d  = rom_data;
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            ready_d = 1'b0;
                        end
                    end else if (rom_ack) begin
                        pf_data_d  = rom_data;
                        pf_valid_d = 1'b1;
                        req_d      = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        pf_fetch_d = 1'b1;
                    end
                end else
`endif
                if (trig) begin
                    if (rom_ack) rom_addr_d = mem_addr(addr_d);
                    else         state_d    = DISCARD;
                end else if (rom_ack) begin
                    data_d  = rom_data;
                    ready_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (rom_ack) begin
                    state_d    = REQ;
                    rom_addr_d = mem_addr(addr_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            rom_addr_q <= SAMPLE_BASE;
            boot_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            rom_addr_q <= rom_addr_d;
            boot_q     <= 1'b0;
        end
    end

`ifdef SAMPLE_PREFETCH_EN
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            pf_data_q  <= 8'h00;
            pf_valid_q <= 1'b0;
            pf_fetch_q <= 1'b0;
        end else begin
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
            pf_fetch_q <= pf_fetch_d;
        end
    end
`endif

    assign sample_rom_data = data_q;
    assign sample_ready    = ready_q;
    assign rom_req         = req_q;
    assign rom_addr        = rom_addr_q;

endmodule

// File: tb/tb_sample_rom_fetch.sv
// Directed bench for sample_rom_fetch with a variable-latency memory responder.
// Prefetch steps run only when SAMPLE_PREFETCH_EN is defined.
module tb_sample_rom_fetch;

    localparam logic [24:0] BASE = 25'h100000;

    logic        CLK_32M = 1'b0;
    logic        reset_n;
    logic [1:0]  sample_addr_wr;
    logic [7:0]  sample_addr;
    logic        sample_inc;
    logic [7:0]  sample_rom_data;
    logic        sample_ready;
    logic [24:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;

    int          checks = 0;
    int          passes = 0;
    int          lat    = 0;
    int          acks   = 0;
    int          a0;
    logic [24:0] last_ack_addr = '0;

    always #5 CLK_32M = ~CLK_32M;

    sample_rom_fetch #(
        .ADDR_W      (25),
        .SAMPLE_BASE (BASE)
    ) dut (
        .CLK_32M         (CLK_32M),
        .reset_n         (reset_n),
        .sample_addr_wr  (sample_addr_wr),
        .sample_addr     (sample_addr),
        .sample_inc      (sample_inc),
        .sample_rom_data (sample_rom_data),
        .sample_ready    (sample_ready),
        .rom_addr        (rom_addr),
        .rom_req         (rom_req),
        .rom_ack         (rom_ack),
        .rom_data        (rom_data)
    );

    // Memory contents: byte = a[7:0] ^ 8'h80 ^ (a[15:8] << 1)
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h80 ^ {a[14:8], 1'b0};
    endfunction

    initial begin : mem
        int          wait_n;
        logic [24:0] off;
        wait_n   = 0;
        rom_ack  = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(negedge CLK_32M);
            rom_ack = 1'b0;
            if (rom_req && reset_n) begin
                if (wait_n >= lat) begin
                    off      = rom_addr - BASE;
                    rom_ack  = 1'b1;
                    rom_data = mem_byte(off[15:0]);
                    wait_n   = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    always @(posedge CLK_32M) begin
        if (reset_n && rom_ack) begin
            acks++;
            last_ack_addr = rom_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [1:0] wr, input logic [7:0] b,
                         input logic inc);
        @(negedge CLK_32M);
        sample_addr_wr = wr;
        sample_addr    = b;
        sample_inc     = inc;
        @(negedge CLK_32M);
        sample_addr_wr = 2'b00;
        sample_inc     = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int max);
        int n;
        n = 0;
        do begin
            @(posedge CLK_32M);
            #1;
            n++;
        end while (!sample_ready && n < max);
        check(tag, {31'd0, sample_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        sample_addr_wr = 2'b00;
        sample_addr    = 8'h00;
        sample_inc     = 1'b0;
        lat            = 2;

        repeat (2) @(posedge CLK_32M);
        #1;
        check("rst_data",  {24'd0, sample_rom_data}, 32'h00);
        check("rst_ready", {31'd0, sample_ready},    32'd0);
        check("rst_req",   {31'd0, rom_req},         32'd0);
        check("rst_addr",  {7'd0, rom_addr},         32'h100000);

        @(negedge CLK_32M);
        reset_n = 1'b1;
        @(posedge CLK_32M);
        #1;
        check("boot_req",   {31'd0, rom_req},      32'd1);
        check("boot_addr",  {7'd0, rom_addr},      32'h100000);
        check("boot_ready", {31'd0, sample_ready}, 32'd0);
        wait_ready("boot_to", 20);
        check("boot_data",  {24'd0, sample_rom_data}, 32'h80);
        check("boot_ackad", {7'd0, last_ack_addr},    32'h100000);

        // low byte then high byte; first fetch goes stale
        a0 = acks;
        pulse(2'b01, 8'h34, 1'b0);
        check("ld_lo_addr",  {7'd0, rom_addr},      32'h100034);
        check("ld_lo_ready", {31'd0, sample_ready}, 32'd0);
        pulse(2'b10, 8'h12, 1'b0);
        check("ld_hi_ready", {31'd0, sample_ready}, 32'd0);
        wait_ready("ld_to", 40);
        check("ld_acks",  acks - a0,                   32'd2);
        check("ld_ackad", {7'd0, last_ack_addr},       32'h101234);
        check("ld_data",  {24'd0, sample_rom_data},    32'h90);

        lat = 0;
        pulse(2'b11, 8'hFF, 1'b0);
        wait_ready("wrp_to0", 20);
        check("wrp_pre", {24'd0, sample_rom_data}, 32'h81);
        pulse(2'b00, 8'h00, 1'b1);
        check("wrp_addr", {7'd0, rom_addr}, 32'h100000);
`ifndef SAMPLE_PREFETCH_EN
        check("wrp_ready", {31'd0, sample_ready}, 32'd0);
`endif
        wait_ready("wrp_to1", 20);
        check("wrp_data", {24'd0, sample_rom_data}, 32'h80);

        // write during a slow fetch: stale data must not appear
        lat = 10;
        a0  = acks;
        pulse(2'b01, 8'h78, 1'b0);
        check("st_addr0", {7'd0, rom_addr}, 32'h100078);
        pulse(2'b10, 8'h56, 1'b0);
        check("st_hold",  {7'd0, rom_addr},      32'h100078);
        check("st_req",   {31'd0, rom_req},      32'd1);
        check("st_ready", {31'd0, sample_ready}, 32'd0);
        wait_ready("st_to", 80);
        check("st_acks",  acks - a0,                32'd2);
        check("st_ackad", {7'd0, last_ack_addr},    32'h105678);
        check("st_data",  {24'd0, sample_rom_data}, 32'h54);

        lat = 0;
        pulse(2'b01, 8'h9A, 1'b1);
        check("col_addr", {7'd0, rom_addr}, 32'h10569A);
        wait_ready("col_to", 20);
        check("col_data", {24'd0, sample_rom_data}, 32'hB6);

`ifndef SAMPLE_PREFETCH_EN
        // zero-latency memory: ready two cycles after the trigger
        pulse(2'b00, 8'h00, 1'b1);
        check("lat_rdy0", {31'd0, sample_ready}, 32'd0);
        @(posedge CLK_32M);
        #1;
        check("lat_rdy1", {31'd0, sample_ready},    32'd1);
        check("lat_data", {24'd0, sample_rom_data}, 32'hB7);
`else
        pulse(2'b10, 8'h00, 1'b0);
        pulse(2'b01, 8'h10, 1'b0);
        wait_ready("pf_to0", 20);
        check("pf_data0", {24'd0, sample_rom_data}, 32'h90);
        repeat (8) @(posedge CLK_32M);
        #1;
        check("pf_idle", {31'd0, rom_req}, 32'd0);
        pulse(2'b00, 8'h00, 1'b1);
        check("pf_ready", {31'd0, sample_ready},    32'd1);
        check("pf_data1", {24'd0, sample_rom_data}, 32'h91);
        begin : pf_wait
            int n;
            n = 0;
            while (!rom_req && n < 10) begin
                @(posedge CLK_32M);
                #1;
                n++;
            end
        end
        check("pf_nreq",  {31'd0, rom_req},      32'd1);
        check("pf_naddr", {7'd0, rom_addr},      32'h100012);
        check("pf_ready2", {31'd0, sample_ready}, 32'd1);
`endif

        // reset with a request outstanding
        lat = 10;
        pulse(2'b01, 8'h11, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_req",   {31'd0, rom_req},         32'd0);
        check("mr_ready", {31'd0, sample_ready},    32'd0);
        check("mr_data",  {24'd0, sample_rom_data}, 32'h00);
        check("mr_addr",  {7'd0, rom_addr},         32'h100000);
        @(negedge CLK_32M);
        reset_n = 1'b1;
        lat     = 1;
        wait_ready("mr_to", 30);
        check("mr_boot", {24'd0, sample_rom_data}, 32'h80);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
